// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on a req/ack port, aligns and extends load
// data, and hands pc/rd/wselector plus the merged data word to write-back.
module mem_access #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   output logic                  done,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic [2:0]            funct3,
   input  logic [31:0]           addr,
   input  logic [31:0]           store_data,
   input  logic [31:0]           ex_result,
   input  logic [31:0]           pc_in,
   input  logic [4:0]            rd_in,
   input  logic [2:0]            wselector_in,
   output logic [31:0]           pc,
   output logic [4:0]            rd,
   output logic [2:0]            wselector,
   output logic [31:0]           data,
   output logic                  misaligned,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_wstrb,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

   state_t      state, nxt;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic        mem_op, mis_now;
   logic [3:0]  strb;
   logic [31:0] wd, ld;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic        unused_ok;

   assign unused_ok = &{1'b0, addr[31:ADDR_WIDTH+2]};
   assign mem_op    = is_load | is_store;
   assign done      = (state == FIN);

   // funct3[1:0] encodes the access size; bit 2 only selects zero-extension on loads
   always_comb begin
      mis_now = 1'b0;
      strb    = 4'b1111;
      wd      = store_data;
      case (funct3[1:0])
         2'b00: begin
            strb = 4'b0001 << addr[1:0];
            wd   = {4{store_data[7:0]}};
         end
         2'b01: begin
            mis_now = addr[0];
            strb    = 4'b0011 << {addr[1], 1'b0};
            wd      = {2{store_data[15:0]}};
         end
         2'b10: mis_now = (addr[1:0] != 2'b00);
         default: ;
      endcase
      mis_now = mis_now & mem_op;
   end

   always_comb begin
      ld_b = mem_rdata[7:0];
      case (lane_q)
         2'd1: ld_b = mem_rdata[15:8];
         2'd2: ld_b = mem_rdata[23:16];
         2'd3: ld_b = mem_rdata[31:24];
         default: ;
      endcase
      ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld = {{24{ld_b[7]}}, ld_b};
         3'b100:  ld = {24'd0, ld_b};
         3'b001:  ld = {{16{ld_h[15]}}, ld_h};
         3'b101:  ld = {16'd0, ld_h};
         default: ld = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (enable) nxt = (mem_op && !mis_now) ? REQ : FIN;
         REQ:     if (mem_ack) nxt = FIN;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc         <= '0;
         rd         <= '0;
         wselector  <= '0;
         data       <= '0;
         misaligned <= 1'b0;
         f3_q       <= '0;
         lane_q     <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wstrb  <= '0;
         mem_wdata  <= '0;
      end else begin
         if (state == IDLE && enable) begin
            pc         <= pc_in;
            rd         <= rd_in;
            wselector  <= {wselector_in[2], wselector_in[1] & ~mis_now, wselector_in[0]};
            data       <= ex_result;
            misaligned <= mis_now;
            f3_q       <= funct3;
            lane_q     <= addr[1:0];
            if (mem_op && !mis_now) begin
               mem_req   <= 1'b1;
               mem_we    <= is_store;
               mem_addr  <= addr[ADDR_WIDTH+1:2];
               mem_wstrb <= is_store ? strb : 4'b0000;
               mem_wdata <= wd;
            end
         end
         if (state == REQ && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            // stores keep ex_result, which was captured at enable
            if (!mem_we) data <= ld;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a bench-side memory responder with variable ack delay
// and a reference model of the load/store alignment rules.
module tb_mem_access;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rstn, enable, done, is_load, is_store;
   logic [2:0]    funct3, wselector_in, wselector;
   logic [31:0]   addr, store_data, ex_result, pc_in, pc, data, mem_wdata, mem_rdata;
   logic [4:0]    rd_in, rd;
   logic          misaligned, mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wstrb;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .done(done),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
      .store_data(store_data), .ex_result(ex_result), .pc_in(pc_in), .rd_in(rd_in),
      .wselector_in(wselector_in), .pc(pc), .rd(rd), .wselector(wselector),
      .data(data), .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                            input logic [31:0] r);
      int unsigned b, h;
      b = (r >> (8 * lane)) & 255;
      h = (r >> (16 * (lane / 2))) & 65535;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd5:    return h;
         default: return r;
      endcase
   endfunction

   function automatic logic [31:0] rnd32();
      return $urandom;
   endfunction

   // One transaction, entered and left on a negedge.
   task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] exr, input logic [31:0] rdat,
                      input int dly, input bit stray);
      logic [31:0] pcv, expd;
      logic [4:0]  rdv;
      logic [2:0]  wsv, f3sz;
      logic [3:0]  estrb;
      logic [31:0] ewd;
      bit          mem, mis;
      int          lane;
      pcv  = rnd32();
      rdv  = 5'($urandom);
      wsv  = 3'($urandom);
      lane = int'(a % 4);
      mem  = ld | st;
      f3sz = f3 & 3'b011;
      mis  = mem && ((f3sz == 1 && (a % 2) != 0) || (f3sz == 2 && lane != 0));
      case (f3sz)
         3'd0:    begin estrb = 4'(1 << lane);       ewd = (sd & 255) * 32'h01010101; end
         3'd1:    begin estrb = 4'(3 << (lane & 2)); ewd = (sd & 65535) * 32'h00010001; end
         default: begin estrb = 4'hF;                ewd = sd; end
      endcase
      expd = (mem && !mis && !st) ? ref_load(f3, lane, rdat) : exr;

      enable = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a;
      store_data = sd; ex_result = exr; pc_in = pcv; rd_in = rdv; wselector_in = wsv;
      @(negedge clk);
      // scramble inputs so that only registered values can satisfy the checks
      enable = 1'b0; pc_in = rnd32(); ex_result = rnd32(); rd_in = 5'($urandom);
      wselector_in = 3'($urandom); addr = rnd32(); store_data = rnd32();
      funct3 = 3'($urandom);
      if (!mem || mis) begin
         chk("done_fast", 32'(done), 1);
         chk("no_req", 32'(mem_req), 0);
      end else begin
         chk("req", 32'(mem_req), 1);
         chk("we", 32'(mem_we), 32'(st));
         chk("maddr", 32'(mem_addr), (a >> 2) & ((1 << AW) - 1));
         chk("wstrb", 32'(mem_wstrb), st ? 32'(estrb) : 0);
         if (st) chk("wdata", mem_wdata, ewd);
         chk("done_early", 32'(done), 0);
         for (int k = 0; k < dly; k++) begin
            if (stray && k == 0) begin
               enable = 1'b1; is_load = 1'b0; is_store = 1'b0;
            end
            @(negedge clk);
            enable = 1'b0;
            chk("req_hold", 32'(mem_req), 1);
            chk("maddr_hold", 32'(mem_addr), (a >> 2) & ((1 << AW) - 1));
            chk("wstrb_hold", 32'(mem_wstrb), st ? 32'(estrb) : 0);
            chk("done_wait", 32'(done), 0);
         end
         mem_ack = 1'b1; mem_rdata = rdat;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = rnd32();
         chk("done_ack", 32'(done), 1);
         chk("req_drop", 32'(mem_req), 0);
         chk("we_drop", 32'(mem_we), 0);
         chk("wstrb_drop", 32'(mem_wstrb), 0);
      end
      chk("data", data, expd);
      chk("pc", pc, pcv);
      chk("rd", 32'(rd), 32'(rdv));
      chk("wsel", 32'(wselector), mis ? 32'(wsv & 3'b101) : 32'(wsv));
      chk("misaligned", 32'(misaligned), 32'(mis));
      // ack seen outside REQ must have no effect
      mem_ack = 1'($urandom);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("done_single", 32'(done), 0);
      chk("req_idle", 32'(mem_req), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; enable = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
      addr = '0; store_data = '0; ex_result = '0; pc_in = '0; rd_in = '0;
      wselector_in = '0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 0);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_data", data, 0);
      chk("rst_pc", pc, 0);
      chk("rst_wsel", 32'(wselector), 0);
      chk("rst_mis", 32'(misaligned), 0);
      rstn = 1'b1;
      @(negedge clk);

      run(1, 0, 3'd0, 32'h1003, 32'h0, 32'h11111111, 32'h80FF1234, 0, 0);
      chk("t1_lb", data, 32'hFFFFFF80);
      run(1, 0, 3'd5, 32'h0002, 32'h0, 32'h22222222, 32'hBEEF0000, 0, 0);
      chk("t2_lhu", data, 32'h0000BEEF);
      run(1, 0, 3'd1, 32'h0002, 32'h0, 32'h22222222, 32'hBEEF0000, 1, 0);
      chk("t2_lh", data, 32'hFFFFBEEF);
      run(0, 1, 3'd0, 32'h0001, 32'h000000AB, 32'hCAFEF00D, 32'h0, 0, 0);
      chk("t3_sb", data, 32'hCAFEF00D);
      run(0, 0, 3'd2, 32'h0040, 32'h0, 32'h12345678, 32'h0, 0, 0);
      chk("t4_alu", data, 32'h12345678);
      run(1, 0, 3'd2, 32'h0100, 32'h0, 32'h0, 32'hA5A5_5A5A, 5, 1);
      run(1, 0, 3'd2, 32'h0002, 32'h0, 32'h33333333, 32'h0, 0, 0);
      chk("t6_mis", 32'(misaligned), 1);
      run(1, 1, 3'd1, 32'h0006, 32'h0000BEEF, 32'h44444444, 32'h0, 2, 0);
      run(1, 0, 3'd0, 32'h0004, 32'h0, 32'h0, 32'h7F, 0, 0);
      chk("mis_cleared", 32'(misaligned), 0);

      // reset in the middle of an access
      enable = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h200;
      pc_in = 32'hDEADBEEF;
      @(negedge clk);
      enable = 1'b0;
      chk("rreq_pre", 32'(mem_req), 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rreq_post", 32'(mem_req), 0);
      chk("rdone_post", 32'(done), 0);
      chk("rpc_post", pc, 0);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rdone_after", 32'(done), 0);
      end

      for (int i = 0; i < 200; i++) begin
         int op;
         logic [2:0] f3;
         logic [2:0] ldf3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         op = $urandom_range(0, 3);
         f3 = (op == 1) ? ldf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         run(op == 1 || op == 3, op >= 2, f3, rnd32(), rnd32(), rnd32(), rnd32(),
             $urandom_range(0, 5), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
